r16_wb_buffer: RTL and testbench
================================

// Module: r16_wb_buffer
// PURPOSE
//  Downstream writeback stage for the radix-16 NTT butterfly top. Captures one 16-lane result group per
//  handshake: data, MA addresses and BN bank numbers. Buffers up to DEPTH groups.
//  Drains one group per cycle into 16 single-port memory banks through a bank crossbar.
//  Counts written groups and pulses stage_done when a full NTT stage has been written back.
// PARAMETERS
//  DEPTH   4    result-group FIFO entries (power of 2, >=2)
//  ADDR_W  8    bank address width; MA idx is truncated to its low ADDR_W bits
//  CNT_W   16   width of group_total and the internal group counter
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous, active-high reset
//  in_valid     in   1                 butterfly result group valid (ntt_done of butterfly top)
//  in_ready     out  1                 buffer can accept a group this cycle
//  y            in   16x`D_width       lane results y0..y15
//  ma_idx       in   16x`D_width       per-lane memory address (R16_MA*_idx_out)
//  bn_idx       in   16x`D_width       per-lane bank number (R16_BN*_idx_out); low 4 bits used
//  group_total  in   CNT_W             groups per stage; sampled when the counter is 0; 0 treated as 1
//  wr_ready     in   1                 memory side accepts writes this cycle
//  bank_we      out  16                per-bank write enable
//  bank_addr    out  16xADDR_W         per-bank address
//  bank_wdata   out  16x`D_width       per-bank write data
//  stage_done   out  1                 one-cycle pulse with the last write of a stage
//  bank_conflict out 1                 sticky error: duplicate bank number within one group
// BEHAVIOUR
//  Reset: FIFO empty, counter 0, all outputs 0; in_ready is 1 one cycle after reset deassertion.
//  Reset mid-operation discards all buffered groups; no partial writes are emitted.
//  Push:
//   - Accept when in_valid && in_ready.
//   - in_ready = (occupancy < DEPTH), derived from registered occupancy only.
//   - When the FIFO is full, no push occurs in the same cycle as a pop.
//  Pop:
//   - Occurs when the FIFO is non-empty && wr_ready.
//   - The head group is routed so that lane i lands in bank bn_idx[i][3:0] at address ma_idx[i][ADDR_W-1:0].
//   - bank_we/addr/wdata are registered. They are valid the cycle after the pop edge and are 0/hold otherwise.
//  Latency: a group accepted at edge k, with wr_ready high, drives bank_we during the cycle after edge k+1.
//   - With wr_ready held high, throughput is 1 group/cycle.
//  Simultaneous push and pop when not full: occupancy unchanged; pointers wrap modulo DEPTH.
//  Empty && in_valid: no same-cycle bypass; the group is written to the FIFO first.
//  wr_ready low: no pop, bank_we=0 next cycle, FIFO contents held.
//  Bank conflict (two lanes share a bank):
//   - The lowest-numbered lane wins that bank; the others are dropped.
//   - bank_conflict sets and stays set until reset.
//   - The conflict is checked on the popped group.
//  Counter:
//   - Increments per pop.
//   - On the pop where counter == group_total-1, stage_done=1 in the same cycle as that group's bank_we.
//   - On that same pop the counter returns to 0.
//  group_total is re-sampled only while the counter is 0; changes mid-stage are ignored.
//  Arithmetic: counter compare is unsigned CNT_W; addresses and data are passed through without modification.
// STRUCTURE
//  Shared package r16_pkg:
//   - localparam LANES=16, BANK_W=4.
//   - typedef lane_data_t [`D_width-1:0].
//   - typedef r16_group_t struct {lane_data_t y[16]; ma[16]; bn[16]}.
//  Sub-module r16_wb_xbar:
//   - Combinational 16x16 lane->bank router with priority conflict detect.
//   - Outputs we/addr/wdata/conflict.
//  Top level holds the FIFO storage, pointers, occupancy, group counter and output registers.
// TESTING
//  1 Identity: bn_idx[i]=i, ma_idx[i]=3, y[i]=100+i, group_total=1, wr_ready=1
//    -> bank_we=16'hFFFF 2 edges after accept; bank i gets addr 3, data 100+i; stage_done=1 in the same cycle.
//  2 Permutation: bn_idx[i]=15-i, y[i]=i
//    -> bank 15-i receives i; bank_conflict stays 0.
//  3 Backpressure: wr_ready=0, push 5 groups back-to-back
//    -> in_ready drops after the 4th accept; the 5th is held upstream.
//    -> Raise wr_ready: 4 consecutive write cycles, in FIFO order, then the 5th.
//  4 Stage count: group_total=3, push 6 groups
//    -> stage_done pulses on the 3rd and 6th writes only; counter is 0 afterwards.
//  5 Conflict: bn_idx[2]=bn_idx[9]=5
//    -> bank 5 gets lane 2 data; bank_conflict=1 and stays set over later clean groups.
//  6 Reset mid-drain: 3 groups buffered, assert rst for 1 cycle
//    -> bank_we=0 immediately; no further writes; in_ready=1 after release.

Source files
------------

// File: rtl/r16_pkg.sv
// Shared types and constants for the radix-16 NTT writeback path.
`ifndef D_width
`define D_width 16
`endif

package r16_pkg;

   localparam int LANES  = 16;
   localparam int BANK_W = 4;
   localparam int DATA_W = `D_width;

   typedef logic [DATA_W-1:0] lane_data_t;

   // One butterfly result group: per-lane data, memory address and bank number.
   typedef struct {
      lane_data_t y  [LANES];
      lane_data_t ma [LANES];
      lane_data_t bn [LANES];
   } r16_group_t;

endpackage

// File: rtl/r16_wb_xbar.sv
// Combinational lane->bank crossbar. Lane i is steered to bank bn[i][3:0];
// when several lanes name the same bank the lowest-numbered lane wins and
// the conflict flag is raised.
module r16_wb_xbar
   import r16_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  r16_group_t                        grp,
   output logic       [LANES-1:0]            we,
   output logic       [LANES-1:0][ADDR_W-1:0] addr,
   output lane_data_t [LANES-1:0]            wdata,
   output logic                              conflict
);

   // Route lanes to banks, walking from the highest lane down so lower lanes overwrite.
   always_comb begin
      logic [BANK_W-1:0] bank;
      // NOTE: every output gets a default before the loop; an unassigned path in
      // always_comb would otherwise infer a latch.
      we    = '0;
      addr  = '0;
      wdata = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         bank        = grp.bn[i][BANK_W-1:0];
         we[bank]    = 1'b1;
         addr[bank]  = grp.ma[i][ADDR_W-1:0];
         wdata[bank] = grp.y[i];
      end
   end

   // Flag any bank claimed by more than one lane.
   always_comb begin
      logic [LANES-1:0]  claimed;
      logic [BANK_W-1:0] bank;
      claimed  = '0;
      conflict = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         bank = grp.bn[i][BANK_W-1:0];
         if (claimed[bank]) conflict = 1'b1;
         claimed[bank] = 1'b1;
      end
   end

endmodule

// File: rtl/r16_wb_buffer.sv
// Writeback buffer for the radix-16 NTT butterfly: queues result groups,
// drains one group per cycle into 16 memory banks and tracks stage completion.
module r16_wb_buffer
   import r16_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  lane_data_t [LANES-1:0]            y,
   input  lane_data_t [LANES-1:0]            ma_idx,
   input  lane_data_t [LANES-1:0]            bn_idx,
   input  logic       [CNT_W-1:0]            group_total,
   input  logic                              wr_ready,
   output logic       [LANES-1:0]            bank_we,
   output logic       [LANES-1:0][ADDR_W-1:0] bank_addr,
   output lane_data_t [LANES-1:0]            bank_wdata,
   output logic                              stage_done,
   output logic                              bank_conflict
);

   localparam int PTR_W = $clog2(DEPTH);

   r16_group_t                        mem_q [DEPTH];
   r16_group_t                        in_group;
   logic       [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic       [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic       [PTR_W:0]              count_q, count_d;
   logic                              in_ready_q, in_ready_d;
   logic       [CNT_W-1:0]            cnt_q, cnt_d;
   logic       [CNT_W-1:0]            total_q, total_d;
   logic       [LANES-1:0]            bank_we_q, bank_we_d;
   logic       [LANES-1:0][ADDR_W-1:0] bank_addr_q, bank_addr_d;
   lane_data_t [LANES-1:0]            bank_wdata_q, bank_wdata_d;
   logic                              stage_done_q, stage_done_d;
   logic                              conflict_q, conflict_d;

   logic                              push, pop, last;
   logic       [CNT_W-1:0]            eff_total;
   logic       [LANES-1:0]            x_we;
   logic       [LANES-1:0][ADDR_W-1:0] x_addr;
   lane_data_t [LANES-1:0]            x_wdata;
   logic                              x_conflict;

   assign push = in_valid && in_ready_q;
   assign pop  = (count_q != '0) && wr_ready;

   // Pack the incoming lanes into a group record for storage.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         in_group.y[i]  = y[i];
         in_group.ma[i] = ma_idx[i];
         in_group.bn[i] = bn_idx[i];
      end
   end

   r16_wb_xbar #(
      .ADDR_W (ADDR_W)
   ) u_xbar (
      .grp      (mem_q[rd_ptr_q]),
      .we       (x_we),
      .addr     (x_addr),
      .wdata    (x_wdata),
      .conflict (x_conflict)
   );

   // Next-state for pointers, occupancy, stage counter and output registers.
   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d      = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      if (!push && pop) count_d = count_q - 1'b1;
      in_ready_d   = count_d < (PTR_W+1)'(DEPTH);

      // The stage length is latched only at the start of a stage; 0 means 1.
      if (cnt_q == '0) eff_total = (group_total == '0) ? CNT_W'(1) : group_total;
      else             eff_total = total_q;
      total_d      = eff_total;
      last         = pop && (cnt_q == eff_total - CNT_W'(1));
      cnt_d        = cnt_q;
      if (last)     cnt_d = '0;
      else if (pop) cnt_d = cnt_q + CNT_W'(1);

      bank_we_d    = pop ? x_we    : '0;
      bank_addr_d  = pop ? x_addr  : bank_addr_q;
      bank_wdata_d = pop ? x_wdata : bank_wdata_q;
      stage_done_d = last;
      conflict_d   = conflict_q || (pop && x_conflict);
   end

   // Group storage.
   // NOTE: the storage array has no reset; the pointers and occupancy define
   // which entries are live, so clearing the data would only cost area.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_group;
   end

   // Control and output registers.
   // NOTE: sequential state uses non-blocking assignment so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_ready_q   <= 1'b0;
         cnt_q        <= '0;
         total_q      <= '0;
         bank_we_q    <= '0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         stage_done_q <= 1'b0;
         conflict_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
         total_q      <= total_d;
         bank_we_q    <= bank_we_d;
         bank_addr_q  <= bank_addr_d;
         bank_wdata_q <= bank_wdata_d;
         stage_done_q <= stage_done_d;
         conflict_q   <= conflict_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign bank_we       = bank_we_q;
   assign bank_addr     = bank_addr_q;
   assign bank_wdata    = bank_wdata_q;
   assign stage_done    = stage_done_q;
   assign bank_conflict = conflict_q;

endmodule

// File: tb/tb_r16_wb_buffer.sv
// Directed bench for r16_wb_buffer: a table of single-group routing vectors
// followed by hand-written backpressure, stage-count and reset sequences.
module tb_r16_wb_buffer;
   import r16_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 16;

   logic                              clk = 1'b0;
   logic                              rst;
   logic                              in_valid;
   logic                              in_ready;
   lane_data_t [LANES-1:0]            y_in, ma_in, bn_in;
   logic       [CNT_W-1:0]            group_total;
   logic                              wr_ready;
   logic       [LANES-1:0]            bank_we;
   logic       [LANES-1:0][ADDR_W-1:0] bank_addr;
   lane_data_t [LANES-1:0]            bank_wdata;
   logic                              stage_done;
   logic                              bank_conflict;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   r16_wb_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .y             (y_in),
      .ma_idx        (ma_in),
      .bn_idx        (bn_in),
      .group_total   (group_total),
      .wr_ready      (wr_ready),
      .bank_we       (bank_we),
      .bank_addr     (bank_addr),
      .bank_wdata    (bank_wdata),
      .stage_done    (stage_done),
      .bank_conflict (bank_conflict)
   );

   typedef struct {
      string                             name;
      logic       [LANES-1:0][3:0]       bn;
      lane_data_t [LANES-1:0]            ma;
      lane_data_t [LANES-1:0]            y;
      logic       [LANES-1:0]            exp_we;
      logic       [LANES-1:0][ADDR_W-1:0] exp_addr;
      lane_data_t [LANES-1:0]            exp_data;
      logic                              exp_conflict;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_group(input logic [LANES-1:0][3:0] bn, input lane_data_t [LANES-1:0] ma,
                            input lane_data_t [LANES-1:0] yv);
      for (int i = 0; i < LANES; i++) begin
         bn_in[i] = lane_data_t'(bn[i]);
         ma_in[i] = ma[i];
         y_in[i]  = yv[i];
      end
   endtask

   // Identity-banked group tagged g: lane i -> bank i, address g, data g*16+i.
   task automatic set_tagged(input int g);
      for (int i = 0; i < LANES; i++) begin
         bn_in[i] = lane_data_t'(i);
         ma_in[i] = lane_data_t'(g);
         y_in[i]  = lane_data_t'(g * 16 + i);
      end
   endtask

   // Present the current group and hold it until accepted (bounded wait).
   task automatic push_group(input string tag);
      int t;
      t = 0;
      in_valid = 1'b1;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_ready"}, 256'(in_ready), 256'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      // ---------------- vector table ----------------
      for (int v = 0; v < 5; v++) begin
         vecs[v].exp_we       = 16'hFFFF;
         vecs[v].exp_conflict = 1'b0;
         vecs[v].exp_addr     = '0;
         vecs[v].exp_data     = '0;
      end
      vecs[0].name = "identity";
      for (int i = 0; i < LANES; i++) begin
         vecs[0].bn[i] = 4'(i); vecs[0].ma[i] = 16'(3); vecs[0].y[i] = 16'(100 + i);
         vecs[0].exp_addr[i] = 8'(3); vecs[0].exp_data[i] = 16'(100 + i);
      end
      vecs[1].name = "permute";
      for (int i = 0; i < LANES; i++) begin
         vecs[1].bn[i] = 4'(15 - i); vecs[1].ma[i] = 16'(i); vecs[1].y[i] = 16'(i);
         vecs[1].exp_addr[15-i] = 8'(i); vecs[1].exp_data[15-i] = 16'(i);
      end
      vecs[2].name = "rotate";
      for (int i = 0; i < LANES; i++) begin
         vecs[2].bn[i] = 4'((i + 5) % 16); vecs[2].ma[i] = 16'(32'h120 + i);
         vecs[2].y[i]  = 16'(32'hA000 + i);
         vecs[2].exp_addr[(i+5)%16] = 8'(32'h20 + i);
         vecs[2].exp_data[(i+5)%16] = 16'(32'hA000 + i);
      end
      vecs[3].name = "conflict";
      for (int i = 0; i < LANES; i++) begin
         vecs[3].bn[i] = 4'(i); vecs[3].ma[i] = 16'(32'h40 + i); vecs[3].y[i] = 16'(32'h300 + i);
         vecs[3].exp_addr[i] = 8'(32'h40 + i); vecs[3].exp_data[i] = 16'(32'h300 + i);
      end
      vecs[3].bn[2] = 4'd5; vecs[3].bn[9] = 4'd5;
      vecs[3].exp_we = 16'hFDFB;
      vecs[3].exp_addr[5] = 8'h42; vecs[3].exp_data[5] = 16'h0302;
      vecs[3].exp_addr[2] = '0; vecs[3].exp_data[2] = '0;
      vecs[3].exp_addr[9] = '0; vecs[3].exp_data[9] = '0;
      vecs[3].exp_conflict = 1'b1;
      vecs[4].name = "clean_after_conflict";
      for (int i = 0; i < LANES; i++) begin
         vecs[4].bn[i] = 4'(i); vecs[4].ma[i] = 16'h0010; vecs[4].y[i] = 16'(32'h700 + i);
         vecs[4].exp_addr[i] = 8'h10; vecs[4].exp_data[i] = 16'(32'h700 + i);
      end
      vecs[4].exp_conflict = 1'b1;

      // ---------------- reset ----------------
      rst = 1'b1; in_valid = 1'b0; wr_ready = 1'b0; group_total = 16'd1;
      y_in = '0; ma_in = '0; bn_in = '0;
      #12;
      check("rst_in_ready", 256'(in_ready), 256'(0));
      check("rst_outputs", 256'({bank_we, stage_done, bank_conflict}), 256'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      check("in_ready_at_release", 256'(in_ready), 256'(0));
      @(posedge clk); #1;
      check("in_ready_after_release", 256'(in_ready), 256'(1));

      // ---------------- table-driven single groups ----------------
      for (int v = 0; v < 5; v++) begin
         logic [LANES-1:0][ADDR_W-1:0] act_addr;
         lane_data_t [LANES-1:0]       act_data;
         group_total = 16'd1;
         wr_ready    = 1'b1;
         set_group(vecs[v].bn, vecs[v].ma, vecs[v].y);
         push_group(vecs[v].name);
         @(posedge clk); #1;
         act_addr = bank_addr;
         act_data = bank_wdata;
         for (int b = 0; b < LANES; b++) begin
            if (!vecs[v].exp_we[b]) begin
               act_addr[b] = '0;
               act_data[b] = '0;
            end
         end
         check({vecs[v].name, "_we"},       256'(bank_we),       256'(vecs[v].exp_we));
         check({vecs[v].name, "_addr"},     256'(act_addr),      256'(vecs[v].exp_addr));
         check({vecs[v].name, "_data"},     256'(act_data),      256'(vecs[v].exp_data));
         check({vecs[v].name, "_done"},     256'(stage_done),    256'(1));
         check({vecs[v].name, "_conflict"}, 256'(bank_conflict), 256'(vecs[v].exp_conflict));
         @(posedge clk); #1;
         check({vecs[v].name, "_we_idle"}, 256'({bank_we, stage_done}), 256'(0));
      end

      // ---------------- backpressure ----------------
      begin
         int acc;
         logic rdy;
         acc = 0;
         wr_ready = 1'b0; group_total = 16'd1;
         set_tagged(0);
         in_valid = 1'b1;
         for (int c = 0; c < 12 && acc < 4; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
               acc++;
               set_tagged(acc);
            end
         end
         check("bp_accepts", 256'(acc), 256'(4));
         check("bp_full_ready", 256'(in_ready), 256'(0));
         @(posedge clk); #1;
         @(posedge clk); #1;
         check("bp_held_ready", 256'(in_ready), 256'(0));
         check("bp_held_no_write", 256'(bank_we), 256'(0));
         wr_ready = 1'b1;
         for (int w = 0; w < 5; w++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) in_valid = 1'b0;
            check($sformatf("bp_we_%0d", w),   256'(bank_we),       256'(16'hFFFF));
            check($sformatf("bp_data_%0d", w), 256'(bank_wdata[0]), 256'(w * 16));
            check($sformatf("bp_addr_%0d", w), 256'(bank_addr[7]),  256'(w));
         end
         check("bp_fifth_taken", 256'(in_valid), 256'(0));
         @(posedge clk); #1;
         check("bp_drained", 256'(bank_we), 256'(0));
      end

      // ---------------- stage count ----------------
      begin
         int pushed, writes;
         logic rdy;
         pushed = 0; writes = 0;
         group_total = 16'd3; wr_ready = 1'b1;
         set_tagged(0);
         in_valid = 1'b1;
         for (int c = 0; c < 12; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
               pushed++;
               if (pushed == 6) in_valid = 1'b0;
               else set_tagged(pushed);
            end
            if (bank_we != '0) begin
               writes++;
               check($sformatf("stage_done_w%0d", writes), 256'(stage_done),
                     256'((writes == 3 || writes == 6) ? 1 : 0));
            end else begin
               check($sformatf("stage_done_idle_c%0d", c), 256'(stage_done), 256'(0));
            end
         end
         check("stage_writes", 256'(writes), 256'(6));

         // Counter back at 0: a one-group stage completes immediately.
         group_total = 16'd1;
         set_tagged(9);
         push_group("stage_restart");
         @(posedge clk); #1;
         check("stage_restart_done", 256'(stage_done), 256'(1));

         // A group_total change mid-stage is ignored.
         group_total = 16'd2;
         set_tagged(10);
         push_group("stage_mid_a");
         @(posedge clk); #1;
         check("stage_mid_a_done", 256'(stage_done), 256'(0));
         group_total = 16'd1;
         set_tagged(11);
         push_group("stage_mid_b");
         @(posedge clk); #1;
         check("stage_mid_b_done", 256'(stage_done), 256'(1));
      end

      // ---------------- reset mid-drain ----------------
      begin
         logic [LANES-1:0] any_we;
         check("conflict_sticky_pre_reset", 256'(bank_conflict), 256'(1));
         wr_ready = 1'b0; group_total = 16'd1;
         for (int g = 0; g < 3; g++) begin
            set_tagged(20 + g);
            push_group($sformatf("rst_fill_%0d", g));
         end
         wr_ready = 1'b1;
         @(posedge clk); #1;
         check("rst_drain_first_we", 256'(bank_we), 256'(16'hFFFF));
         rst = 1'b1;
         #1;
         check("rst_mid_we", 256'(bank_we), 256'(0));
         check("rst_mid_flags", 256'({in_ready, stage_done, bank_conflict}), 256'(0));
         @(posedge clk); #1;
         rst = 1'b0;
         any_we = '0;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            any_we = any_we | bank_we;
         end
         check("rst_no_writes", 256'(any_we), 256'(0));
         check("rst_in_ready", 256'(in_ready), 256'(1));
         set_tagged(30);
         push_group("post_rst");
         @(posedge clk); #1;
         check("post_rst_we", 256'(bank_we), 256'(16'hFFFF));
         check("post_rst_data", 256'(bank_wdata[3]), 256'(30 * 16 + 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
